axi_xbar_wr_arbiter: RTL and testbench
======================================

Name: axi_xbar_wr_arbiter

Overview:
- Write-path arbiter for one crossbar destination port. It shares a single downstream AW/W channel pair among NB_SRC upstream sources.
- AW arbitration is round-robin. The winner's source index is prepended to the AW ID, so the B demux can return responses to the right source.
- Grant order is recorded in a route FIFO. W beats are forwarded strictly in AW grant order, one whole burst at a time.
- An outstanding-write limit is enforced, using B completions reported by the B demux.

Parameters:
- NB_SRC, 4, number of upstream sources; must be >= 2.
- ID_WIDTH, 4, upstream AXI ID width.
- ADDR_WIDTH, 64, address width.
- DATA_WIDTH, 64, data width; strobe width is DATA_WIDTH/8.
- MAX_OUTSTANDING, 8, maximum writes granted but not yet completed by B; also the route FIFO depth; power of two, >= 2.
- Derived: ID_OUT = ID_WIDTH + $clog2(NB_SRC); SIDX_W = $clog2(NB_SRC).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- src_aw_valid  in  NB_SRC  per-source AW valid.
- src_aw_ready  out  NB_SRC  per-source AW ready; one-hot or zero.
- src_aw_id  in  NB_SRC*ID_WIDTH  packed IDs; source i occupies slice i.
- src_aw_addr  in  NB_SRC*ADDR_WIDTH  packed addresses.
- src_aw_len  in  NB_SRC*8  packed burst lengths.
- src_w_valid  in  NB_SRC  per-source W valid.
- src_w_ready  out  NB_SRC  per-source W ready.
- src_w_data  in  NB_SRC*DATA_WIDTH  packed W data.
- src_w_strb  in  NB_SRC*DATA_WIDTH/8  packed W strobes.
- src_w_last  in  NB_SRC  per-source W last.
- dst_aw_valid  out  1  downstream AW valid (registered).
- dst_aw_ready  in  1  downstream AW ready.
- dst_aw_id  out  ID_OUT  {source index, upstream ID}.
- dst_aw_addr  out  ADDR_WIDTH  downstream address.
- dst_aw_len  out  8  downstream burst length.
- dst_w_valid  out  1  downstream W valid.
- dst_w_ready  in  1  downstream W ready.
- dst_w_data  out  DATA_WIDTH  downstream W data.
- dst_w_strb  out  DATA_WIDTH/8  downstream W strobe.
- dst_w_last  out  1  downstream W last.
- b_done  in  1  one-cycle pulse per completed B handshake on this port.
- grant_cnt  out  NB_SRC*32  per-source grant statistics (see Optional Feature).

Behaviour:
- Reset values:
  - dst_aw_valid=0; dst_aw_id/addr/len=0.
  - rr_ptr=0; route FIFO empty; outstanding count=0.
  - All src_*_ready=0; dst_w_valid=0.
- AW output register:
  - slot_free = !dst_aw_valid | dst_aw_ready.
  - can_grant = slot_free & (count < MAX_OUTSTANDING) & !fifo_full.
- Round-robin arbitration:
  - The grantee g is the first asserted src_aw_valid scanning from rr_ptr upward, wrapping modulo NB_SRC.
  - When can_grant is true, src_aw_ready[g]=1 combinationally and all other readies are 0.
  - On grant: the output register loads {g, id_g}, addr_g, len_g; dst_aw_valid=1 next cycle; rr_ptr <= (g+1) mod NB_SRC; g is pushed to the route FIFO.
  - When nothing is granted: rr_ptr is unchanged; dst_aw_valid clears if dst_aw_ready was seen.
  - Throughput is one AW per cycle while dst_aw_ready stays high. Latency is one cycle from source handshake to dst_aw_valid.
- AW stability: while dst_aw_valid=1 and dst_aw_ready=0, all dst_aw_* outputs hold stable.
- Outstanding counter:
  - +1 on grant; −1 on b_done; unchanged when both occur in the same cycle.
  - b_done with count==0 is ignored (no underflow); the testbench flags it with an assertion.
- W routing:
  - Head h = FIFO head, valid when the FIFO is non-empty.
  - dst_w_* = src_w_*[h]; dst_w_valid = !empty & src_w_valid[h]; src_w_ready[h] = !empty & dst_w_ready; all other src_w_ready are 0.
  - Pop on a W handshake with w_last=1.
  - A FIFO push becomes visible at the head the next cycle, so a W beat is never forwarded in the same cycle as its AW grant.
  - Pushing into an empty FIFO while popping is legal. Push and pop on a full FIFO is impossible because can_grant requires !fifo_full.
- Ordering: W bursts leave in exactly AW grant order; interleaving between sources is never allowed.
- Reset mid-burst: all state clears immediately and any partial burst is dropped. System reset of upstream and downstream is required.

Optional Feature:
- Macro: AXI_XBAR_ARB_STATS_EN.
- Defined: each grant_cnt slice i is a 32-bit counter, +1 per AW grant to source i, saturating at 0xFFFFFFFF, reset to 0.
- Undefined: no counters are instantiated and grant_cnt is tied to 0.

Decomposition:
- Package axi_xbar_arb_pkg holds:
  - the function id_out_width(id_w, nb_src);
  - the saturating-increment function;
  - the constant STATS_W=32.
- One sub-module, axi_xbar_route_fifo:
  - synchronous FIFO of SIDX_W-bit entries, depth MAX_OUTSTANDING;
  - outputs full/empty/head.

Test Plan:
- All 4 sources assert AW together, dst_aw_ready=1 → grants 0,1,2,3 on consecutive cycles; dst_aw_id top bits 0,1,2,3; rr_ptr returns to 0.
- Source 2 alone, id=0x5, len=3, NB_SRC=4, ID_WIDTH=4 → dst_aw_id=0x25; 4 W beats forwarded; src_w_ready[2] high only; FIFO pops on the last beat.
- 8 AWs granted with no b_done, MAX_OUTSTANDING=8 → 9th AW stalled (src_aw_ready=0); one b_done pulse → 9th granted next cycle.
- Source 1 W data presented before source 0's, grant order 0 then 1 → source 0 burst sent first; source 1 held until the source 0 w_last handshake.
- dst_aw_ready=0 for 5 cycles → dst_aw_* stable, no new grant; grant and b_done in the same cycle → count unchanged.
- AXI_XBAR_ARB_STATS_EN defined, 10 grants to source 3 → grant_cnt slice 3 = 10, others 0; rst_n low mid-burst → all counters and outputs return to 0.

Source files
------------

// File: rtl/axi_xbar_arb_pkg.sv
// Shared constants and helpers for the crossbar write-path arbiter.
package axi_xbar_arb_pkg;

  localparam int unsigned STATS_W = 32;

  function automatic int unsigned id_out_width(input int unsigned id_w, input int unsigned nb_src);
    return id_w + $clog2(nb_src);
  endfunction

  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    return (v == '1) ? v : v + STATS_W'(1);
  endfunction

endpackage

// File: rtl/axi_xbar_route_fifo.sv
// Route FIFO holding the source index of each granted AW, in grant order.
module axi_xbar_route_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign head_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q[PTR_W-1:0]] <= data_i;
  end

endmodule

// File: rtl/axi_xbar_wr_arbiter.sv
// Round-robin AW arbiter with in-order W routing for one crossbar destination.
// Optional per-source grant counters enabled by AXI_XBAR_ARB_STATS_EN.
module axi_xbar_wr_arbiter import axi_xbar_arb_pkg::*; #(
  parameter  int unsigned NB_SRC          = 4,
  parameter  int unsigned ID_WIDTH        = 4,
  parameter  int unsigned ADDR_WIDTH      = 64,
  parameter  int unsigned DATA_WIDTH      = 64,
  parameter  int unsigned MAX_OUTSTANDING = 8,
  localparam int unsigned SIDX_W          = $clog2(NB_SRC),
  localparam int unsigned ID_OUT          = id_out_width(ID_WIDTH, NB_SRC),
  localparam int unsigned STRB_W          = DATA_WIDTH / 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NB_SRC-1:0]            src_aw_valid,
  output logic [NB_SRC-1:0]            src_aw_ready,
  input  logic [NB_SRC*ID_WIDTH-1:0]   src_aw_id,
  input  logic [NB_SRC*ADDR_WIDTH-1:0] src_aw_addr,
  input  logic [NB_SRC*8-1:0]          src_aw_len,
  input  logic [NB_SRC-1:0]            src_w_valid,
  output logic [NB_SRC-1:0]            src_w_ready,
  input  logic [NB_SRC*DATA_WIDTH-1:0] src_w_data,
  input  logic [NB_SRC*STRB_W-1:0]     src_w_strb,
  input  logic [NB_SRC-1:0]            src_w_last,
  output logic                         dst_aw_valid,
  input  logic                         dst_aw_ready,
  output logic [ID_OUT-1:0]            dst_aw_id,
  output logic [ADDR_WIDTH-1:0]        dst_aw_addr,
  output logic [7:0]                   dst_aw_len,
  output logic                         dst_w_valid,
  input  logic                         dst_w_ready,
  output logic [DATA_WIDTH-1:0]        dst_w_data,
  output logic [STRB_W-1:0]            dst_w_strb,
  output logic                         dst_w_last,
  input  logic                         b_done,
  output logic [NB_SRC*STATS_W-1:0]    grant_cnt
);

  localparam int unsigned     CNT_W   = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [SIDX_W:0]  NB_WRAP = (SIDX_W+1)'(NB_SRC);

  logic [ID_WIDTH-1:0]   aw_id_a   [NB_SRC];
  logic [ADDR_WIDTH-1:0] aw_addr_a [NB_SRC];
  logic [7:0]            aw_len_a  [NB_SRC];
  logic [DATA_WIDTH-1:0] w_data_a  [NB_SRC];
  logic [STRB_W-1:0]     w_strb_a  [NB_SRC];

  logic                  aw_valid_q;
  logic [ID_OUT-1:0]     aw_id_q;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [7:0]            aw_len_q;
  logic [SIDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [SIDX_W:0]   scan;
  logic [SIDX_W-1:0] gnt_idx, w_head;
  logic              gnt_found, can_grant, grant, b_dec;
  logic              fifo_full, fifo_empty, w_pop;

  always_comb begin
    for (int unsigned i = 0; i < NB_SRC; i++) begin
      aw_id_a[i]   = src_aw_id[i*ID_WIDTH +: ID_WIDTH];
      aw_addr_a[i] = src_aw_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      aw_len_a[i]  = src_aw_len[i*8 +: 8];
      w_data_a[i]  = src_w_data[i*DATA_WIDTH +: DATA_WIDTH];
      w_strb_a[i]  = src_w_strb[i*STRB_W +: STRB_W];
    end
  end

  // Scan from rr_ptr upward; the sum is wrapped by one subtraction since it stays below 2*NB_SRC.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan      = '0;
    for (int unsigned k = 0; k < NB_SRC; k++) begin
      scan = {1'b0, rr_ptr_q} + (SIDX_W+1)'(k);
      if (scan >= NB_WRAP) scan = scan - NB_WRAP;
      if (!gnt_found && src_aw_valid[scan[SIDX_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan[SIDX_W-1:0];
      end
    end
  end

  assign can_grant = rst_n && (!aw_valid_q || dst_aw_ready) && (cnt_q < CNT_MAX) && !fifo_full;
  assign grant     = can_grant && gnt_found;
  assign rr_ptr_d  = (gnt_idx == SIDX_W'(NB_SRC - 1)) ? '0 : gnt_idx + SIDX_W'(1);
  assign b_dec     = b_done && (cnt_q != '0);

  always_comb begin
    src_aw_ready = '0;
    if (grant) src_aw_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({grant, b_dec})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_valid_q <= 1'b0;
      aw_id_q    <= '0;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      rr_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      if (grant) begin
        aw_valid_q <= 1'b1;
        aw_id_q    <= {gnt_idx, aw_id_a[gnt_idx]};
        aw_addr_q  <= aw_addr_a[gnt_idx];
        aw_len_q   <= aw_len_a[gnt_idx];
        rr_ptr_q   <= rr_ptr_d;
      end else if (dst_aw_ready) begin
        aw_valid_q <= 1'b0;
      end
      cnt_q <= cnt_d;
    end
  end

  assign dst_aw_valid = aw_valid_q;
  assign dst_aw_id    = aw_id_q;
  assign dst_aw_addr  = aw_addr_q;
  assign dst_aw_len   = aw_len_q;

  axi_xbar_route_fifo #(
    .WIDTH (SIDX_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_route_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (grant),
    .data_i  (gnt_idx),
    .pop_i   (w_pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (w_head)
  );

  assign dst_w_valid = !fifo_empty && src_w_valid[w_head];
  assign dst_w_data  = w_data_a[w_head];
  assign dst_w_strb  = w_strb_a[w_head];
  assign dst_w_last  = src_w_last[w_head];
  assign w_pop       = dst_w_valid && dst_w_ready && dst_w_last;

  always_comb begin
    src_w_ready = '0;
    if (!fifo_empty) src_w_ready[w_head] = dst_w_ready;
  end

`ifdef AXI_XBAR_ARB_STATS_EN
  logic [STATS_W-1:0] stat_q [NB_SRC];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NB_SRC; i++) stat_q[i] <= '0;
    end else if (grant) begin
      stat_q[gnt_idx] <= sat_inc(stat_q[gnt_idx]);
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NB_SRC; i++) grant_cnt[i*STATS_W +: STATS_W] = stat_q[i];
  end
`else
  assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_axi_xbar_wr_arbiter.sv
// Randomized bench for axi_xbar_wr_arbiter with an in-bench queue-based reference model.
module tb_axi_xbar_wr_arbiter;
  import axi_xbar_arb_pkg::*;

  localparam int NB = 4, IDW = 4, AWD = 64, DW = 64, MAXO = 8;
  localparam int SW = 2, IDO = IDW + SW, SB = DW / 8;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [NB-1:0]        src_aw_valid, src_aw_ready, src_w_valid, src_w_ready, src_w_last;
  logic [NB*IDW-1:0]    src_aw_id;
  logic [NB*AWD-1:0]    src_aw_addr;
  logic [NB*8-1:0]      src_aw_len;
  logic [NB*DW-1:0]     src_w_data;
  logic [NB*SB-1:0]     src_w_strb;
  logic                 dst_aw_valid, dst_aw_ready, dst_w_valid, dst_w_ready, dst_w_last, b_done;
  logic [IDO-1:0]       dst_aw_id;
  logic [AWD-1:0]       dst_aw_addr;
  logic [7:0]           dst_aw_len;
  logic [DW-1:0]        dst_w_data;
  logic [SB-1:0]        dst_w_strb;
  logic [NB*STATS_W-1:0] grant_cnt;

  axi_xbar_wr_arbiter #(
    .NB_SRC(NB), .ID_WIDTH(IDW), .ADDR_WIDTH(AWD), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .src_aw_valid(src_aw_valid), .src_aw_ready(src_aw_ready), .src_aw_id(src_aw_id),
    .src_aw_addr(src_aw_addr), .src_aw_len(src_aw_len),
    .src_w_valid(src_w_valid), .src_w_ready(src_w_ready), .src_w_data(src_w_data),
    .src_w_strb(src_w_strb), .src_w_last(src_w_last),
    .dst_aw_valid(dst_aw_valid), .dst_aw_ready(dst_aw_ready), .dst_aw_id(dst_aw_id),
    .dst_aw_addr(dst_aw_addr), .dst_aw_len(dst_aw_len),
    .dst_w_valid(dst_w_valid), .dst_w_ready(dst_w_ready), .dst_w_data(dst_w_data),
    .dst_w_strb(dst_w_strb), .dst_w_last(dst_w_last),
    .b_done(b_done), .grant_cnt(grant_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int oh2i(input logic [NB-1:0] v);
    int r = -1;
    for (int i = 0; i < NB; i++) if (v[i]) r = i;
    return r;
  endfunction

  // ---------------- stimulus state ----------------
  typedef struct packed { logic [IDW-1:0] id; logic [AWD-1:0] addr; logic [7:0] len; } aw_t;
  aw_t aw_q [NB][$];
  int  wq [NB][$];
  int  wbeat [NB];
  bit  aw_hold [NB];
  bit  w_hold [NB];
  int unsigned aw_prob = 100, w_prob = 100, awr_prob = 100, wr_prob = 100;
  bit  b_en = 1'b1, force_b = 1'b0;
  int  bursts_done = 0, b_sent = 0;
  logic [NB-1:0]  snap_awr, snap_wr;
  logic           snap_awv, snap_whs;
  logic [IDO-1:0] snap_awid;

  task automatic clear_stim();
    src_aw_valid = '0; src_aw_id = '0; src_aw_addr = '0; src_aw_len = '0;
    src_w_valid = '0; src_w_data = '0; src_w_strb = '0; src_w_last = '0;
    dst_aw_ready = 1'b0; dst_w_ready = 1'b0; b_done = 1'b0; force_b = 1'b0;
    for (int i = 0; i < NB; i++) begin
      aw_q[i].delete(); wq[i].delete(); wbeat[i] = 0; aw_hold[i] = 1'b0; w_hold[i] = 1'b0;
    end
    bursts_done = 0; b_sent = 0;
  endtask

  task automatic step();
    @(negedge clk);
    snap_awr = src_aw_ready; snap_wr = src_w_ready; snap_awv = dst_aw_valid;
    snap_awid = dst_aw_id; snap_whs = dst_w_valid && dst_w_ready;
    for (int i = 0; i < NB; i++) begin
      aw_hold[i] = src_aw_valid[i] && !src_aw_ready[i];
      if (src_aw_valid[i] && src_aw_ready[i] && aw_q[i].size() > 0) begin
        wq[i].push_back(int'(aw_q[i][0].len));
        void'(aw_q[i].pop_front());
      end
      w_hold[i] = src_w_valid[i] && !src_w_ready[i];
      if (src_w_valid[i] && src_w_ready[i] && wq[i].size() > 0) begin
        if (wbeat[i] >= wq[i][0]) begin void'(wq[i].pop_front()); wbeat[i] = 0; end
        else wbeat[i]++;
      end
    end
    if (dst_w_valid && dst_w_ready && dst_w_last) bursts_done++;
    if (b_done) b_sent++;
    @(posedge clk); #1;
    for (int i = 0; i < NB; i++) begin
      if (!aw_hold[i]) begin
        if (aw_q[i].size() > 0 && $urandom_range(99) < aw_prob) begin
          src_aw_valid[i] = 1'b1;
          src_aw_id[i*IDW +: IDW] = aw_q[i][0].id;
          src_aw_addr[i*AWD +: AWD] = aw_q[i][0].addr;
          src_aw_len[i*8 +: 8] = aw_q[i][0].len;
        end else src_aw_valid[i] = 1'b0;
      end
      if (!w_hold[i]) begin
        if (wq[i].size() > 0 && $urandom_range(99) < w_prob) begin
          src_w_valid[i] = 1'b1;
          src_w_data[i*DW +: DW] = {$urandom, $urandom};
          src_w_strb[i*SB +: SB] = SB'($urandom);
          src_w_last[i] = (wbeat[i] == wq[i][0]);
        end else src_w_valid[i] = 1'b0;
      end
    end
    dst_aw_ready = ($urandom_range(99) < awr_prob);
    dst_w_ready  = ($urandom_range(99) < wr_prob);
    b_done = force_b || (b_en && bursts_done > b_sent && $urandom_range(1) == 1);
    force_b = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_stim();
    @(negedge clk);
    chk("rst_aw_valid", dst_aw_valid, 0);
    chk("rst_grant_cnt", grant_cnt, 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // ---------------- reference model ----------------
  int   m_rr, m_cnt, m_q[$];
  logic m_awv;
  logic [IDO-1:0] m_id;
  logic [AWD-1:0] m_addr;
  logic [7:0]     m_len;
  int unsigned    m_stats [NB];
  logic [NB-1:0]  e_awr, e_wr;
  logic [NB*STATS_W-1:0] e_gc;
  int   g, h;
  bit   can, e_wv;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_rr = 0; m_cnt = 0; m_q.delete(); m_awv = 1'b0; m_id = '0; m_addr = '0; m_len = '0;
      for (int i = 0; i < NB; i++) m_stats[i] = 0;
      chk("reset_aw_ready", src_aw_ready, 0);
      chk("reset_w_ready", src_w_ready, 0);
      chk("reset_w_valid", dst_w_valid, 0);
      chk("reset_aw_id", {dst_aw_valid, dst_aw_id, dst_aw_addr, dst_aw_len}, 0);
    end else begin
      can = (!m_awv || dst_aw_ready) && m_cnt < MAXO && m_q.size() < MAXO;
      g = -1;
      for (int k = 0; k < NB; k++) if (g < 0 && src_aw_valid[(m_rr + k) % NB]) g = (m_rr + k) % NB;
      e_awr = '0;
      if (can && g >= 0) e_awr[g] = 1'b1;
      e_wr = '0; e_wv = 1'b0; h = -1;
      if (m_q.size() > 0) begin h = m_q[0]; e_wv = src_w_valid[h]; e_wr[h] = dst_w_ready; end
      e_gc = '0;
`ifdef AXI_XBAR_ARB_STATS_EN
      for (int i = 0; i < NB; i++) e_gc[i*STATS_W +: STATS_W] = m_stats[i];
`endif
      chk("aw_ready", src_aw_ready, e_awr);
      chk("aw_valid", dst_aw_valid, m_awv);
      chk("aw_id", dst_aw_id, m_id);
      chk("aw_addr", dst_aw_addr, m_addr);
      chk("aw_len", dst_aw_len, m_len);
      chk("w_ready", src_w_ready, e_wr);
      chk("w_valid", dst_w_valid, e_wv);
      chk("grant_cnt", grant_cnt, e_gc);
      if (e_wv) begin
        chk("w_data", dst_w_data, src_w_data[h*DW +: DW]);
        chk("w_strb", dst_w_strb, src_w_strb[h*SB +: SB]);
        chk("w_last", dst_w_last, src_w_last[h]);
      end
      tests++;
      assert (!(b_done && m_cnt == 0)) else begin
        fails++;
        $display("FAIL b_done_underflow: got b_done with outstanding 0 required outstanding >0");
      end
      if (e_wv && dst_w_ready && src_w_last[h]) void'(m_q.pop_front());
      if (e_awr != 0) begin
        m_awv  = 1'b1;
        m_id   = {g[SW-1:0], src_aw_id[g*IDW +: IDW]};
        m_addr = src_aw_addr[g*AWD +: AWD];
        m_len  = src_aw_len[g*8 +: 8];
        m_rr   = (g + 1) % NB;
        m_q.push_back(g);
        if (m_stats[g] != 32'hFFFF_FFFF) m_stats[g]++;
      end else if (dst_aw_ready) m_awv = 1'b0;
      m_cnt = m_cnt + ((e_awr != 0) ? 1 : 0) - ((b_done && m_cnt > 0) ? 1 : 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- directed + random sequences ----------------
  int got[$], tops[$];
  int beats, ngr;
  bit seen;
  logic [127:0] gc_exp;

  initial begin
    clear_stim();
    repeat (3) @(negedge clk);
    @(posedge clk); #1; rst_n = 1'b1;

    // all sources request together: grants 0,1,2,3 back to back
    for (int i = 0; i < NB; i++) aw_q[i].push_back(aw_t'{id: IDW'(i + 8), addr: 64'(i * 16), len: 8'd0});
    repeat (12) begin
      step();
      if (snap_awr != 0) got.push_back(oh2i(snap_awr));
      if (snap_awv) tops.push_back(int'(snap_awid[IDO-1 -: SW]));
    end
    chk("t1_ngrant", got.size(), 4);
    chk("t1_ntops", tops.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < got.size())  chk("t1_grant_order", got[k], k);
      if (k < tops.size()) chk("t1_id_top", tops[k], k);
    end
    // pointer wrapped back to 0: source 0 wins over source 1
    aw_q[1].push_back(aw_t'{id: 4'h1, addr: 64'h10, len: 8'd0});
    aw_q[0].push_back(aw_t'{id: 4'h2, addr: 64'h20, len: 8'd0});
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      step();
      if (snap_awr != 0) begin seen = 1'b1; chk("t1_rr_wrap", snap_awr, 4'b0001); end
    end
    chk("t1_rr_wrap_seen", seen, 1);
    repeat (30) step();

    // single source 2, id 5, 4-beat burst
    aw_q[2].push_back(aw_t'{id: 4'h5, addr: 64'h1000, len: 8'd3});
    beats = 0; seen = 1'b0;
    repeat (20) begin
      step();
      if (snap_awv && !seen) begin seen = 1'b1; chk("t2_aw_id", snap_awid, 6'h25); end
      if (snap_wr != 0) chk("t2_w_ready_onehot", snap_wr, 4'b0100);
      if (snap_whs) beats++;
    end
    chk("t2_beats", beats, 4);
    repeat (10) step();

    // outstanding limit: 9th AW waits for a b_done
    do_reset();
    b_en = 1'b0;
    for (int k = 0; k < 9; k++) aw_q[0].push_back(aw_t'{id: IDW'(k), addr: 64'(k), len: 8'd0});
    ngr = 0;
    repeat (30) begin step(); if (snap_awr != 0) ngr++; end
    chk("t3_grants_at_limit", ngr, 8);
    chk("t3_stalled", snap_awr, 4'b0000);
    force_b = 1'b1;
    step(); step();
    chk("t3_bdone_cycle", snap_awr, 4'b0000);
    step();
    chk("t3_grant9", snap_awr, 4'b0001);
    b_en = 1'b1;
    do_reset();

    // downstream AW stall holds the output register
    aw_q[1].push_back(aw_t'{id: 4'h9, addr: 64'hABCD, len: 8'd0});
    aw_q[1].push_back(aw_t'{id: 4'h3, addr: 64'h1234, len: 8'd0});
    awr_prob = 0;
    repeat (3) step();
    repeat (5) begin
      step();
      chk("t5_hold_valid", snap_awv, 1);
      chk("t5_hold_id", snap_awid, 6'h19);
      chk("t5_no_grant", snap_awr, 4'b0000);
    end
    awr_prob = 100;
    repeat (30) step();

    // ten grants to source 3, then reset mid-burst
    do_reset();
    for (int k = 0; k < 10; k++) aw_q[3].push_back(aw_t'{id: IDW'(k), addr: 64'(k), len: 8'd1});
    repeat (60) step();
    gc_exp = '0;
`ifdef AXI_XBAR_ARB_STATS_EN
    gc_exp = 128'd10 << 96;
`endif
    chk("t6_grant_cnt", grant_cnt, gc_exp);
    aw_q[0].push_back(aw_t'{id: 4'h7, addr: 64'h40, len: 8'd7});
    w_prob = 50;
    repeat (6) step();
    do_reset();
    w_prob = 100;

    // randomized traffic
    for (int r = 0; r < 4; r++) begin
      aw_prob  = $urandom_range(100, 30);
      w_prob   = $urandom_range(100, 30);
      awr_prob = $urandom_range(100, 20);
      wr_prob  = $urandom_range(100, 20);
      for (int i = 0; i < NB; i++)
        for (int k = 0; k < 15; k++)
          aw_q[i].push_back(aw_t'{id: IDW'($urandom), addr: {$urandom, $urandom}, len: 8'($urandom_range(7))});
      repeat (400) step();
      if (r == 1) do_reset();
    end
    aw_prob = 100; w_prob = 100; awr_prob = 100; wr_prob = 100;
    repeat (300) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
